// File: rtl/stdp_weight_updater.sv
// Pair-based STDP synapse: age counters, multiply-add update FSM, saturating write.
// Define STDP_WEIGHT_CLAMP_EN to also clamp each new weight to [w_min, w_max].
module stdp_weight_updater #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int T_WIN = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         apply,
  input  logic         pre_spike,
  input  logic         post_spike,
  input  logic [N-1:0] weight_init,
  input  logic [N-1:0] m1,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] m2,
  input  logic [N-1:0] b2,
  input  logic [N-1:0] w_min,
  input  logic [N-1:0] w_max,
  output logic [N-1:0] weight,
  output logic         update_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int S = 2 * N + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL   = 2'd1;
  localparam logic [1:0] ADD   = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [Q-1:0] AGE_MAX = '1;
  localparam logic [Q:0]   WIN     = (Q + 1)'(T_WIN);
  localparam logic [N-1:0] WMAX    = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0] WMIN    = {1'b1, {(N - 1){1'b0}}};

  logic [1:0]   state;
  logic [Q-1:0] pre_age;
  logic [Q-1:0] post_age;
  logic         pre_seen;
  logic         post_seen;
  logic [N-1:0] m_r;
  logic [N-1:0] b_r;
  logic [Q:0]   dt_r;

  logic signed [2*N-1:0] prod_r;

  logic [Q:0] pre_dt;
  logic [Q:0] post_dt;
  logic       pot;
  logic       dep;
  logic       qual;

  assign pre_dt  = {1'b0, pre_age} + (Q + 1)'(1);
  assign post_dt = {1'b0, post_age} + (Q + 1)'(1);

  // Only the most recent partner spike pairs; stale pairings fall outside the window.
  assign pot = apply && post_spike && !pre_spike && pre_seen
               && (pre_dt <= WIN);
  assign dep = apply && pre_spike && !post_spike && post_seen
               && (post_dt <= WIN);
  assign qual = pot || dep;

  assign busy         = (state != IDLE);
  assign update_valid = (state == WRITE);

  logic signed [2*N-1:0] m_ext;
  logic signed [2*N-1:0] dt_ext;

  assign m_ext  = {{N{m_r[N-1]}}, m_r};
  assign dt_ext = {{(2 * N - Q - 1){1'b0}}, dt_r};

  logic signed [S-1:0] sum;
  logic signed [S-1:0] s_max;
  logic signed [S-1:0] s_min;
  logic [N-1:0]        sat;
  logic [N-1:0]        next_w;

  assign s_max = {{(S - N){1'b0}}, WMAX};
  assign s_min = {{(S - N){1'b1}}, WMIN};

  always_comb begin
    sum = {{2{prod_r[2*N-1]}}, prod_r}
        + {{(S - N){weight[N-1]}}, weight}
        + {{(S - N){b_r[N-1]}}, b_r};
    if (sum > s_max) begin
      sat = WMAX;
    end else if (sum < s_min) begin
      sat = WMIN;
    end else begin
      sat = sum[N-1:0];
    end
  end

`ifdef STDP_WEIGHT_CLAMP_EN
  always_comb begin
    next_w = sat;
    if ($signed(sat) > $signed(w_max)) begin
      next_w = w_max;
    end else if ($signed(sat) < $signed(w_min)) begin
      next_w = w_min;
    end
  end
`else
  logic unused_bounds;

  assign unused_bounds = ^{w_min, w_max};
  assign next_w        = sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      weight    <= weight_init;
      pre_age   <= '0;
      post_age  <= '0;
      pre_seen  <= 1'b0;
      post_seen <= 1'b0;
      overrun   <= 1'b0;
      m_r       <= '0;
      b_r       <= '0;
      dt_r      <= '0;
      prod_r    <= '0;
    end else begin
      overrun <= qual && busy;

      if (apply) begin
        if (pre_spike) begin
          pre_age  <= '0;
          pre_seen <= 1'b1;
        end else if (pre_age != AGE_MAX) begin
          pre_age <= pre_age + 1'b1;
        end
        if (post_spike) begin
          post_age  <= '0;
          post_seen <= 1'b1;
        end else if (post_age != AGE_MAX) begin
          post_age <= post_age + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (qual) begin
            m_r   <= pot ? m1 : m2;
            b_r   <= pot ? b1 : b2;
            dt_r  <= pot ? pre_dt : post_dt;
            state <= MUL;
          end
        end
        MUL: begin
          prod_r <= m_ext * dt_ext;
          state  <= ADD;
        end
        ADD: begin
          weight <= next_w;
          state  <= WRITE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stdp_weight_updater.md
STDP_WEIGHT_UPDATER -- requirements
Module: stdp_weight_updater

Interface
REQ-001 Parameters SHALL be: N, 32, fixed-point word width; Q, 16, fractional bits and age-counter width; T_WIN, 20, max pairing interval in apply steps.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 apply  input  1  single-cycle time-step strobe.
REQ-005 pre_spike  input  1  presynaptic spike flag, sampled only when apply=1.
REQ-006 post_spike  input  1  postsynaptic spike flag, sampled only when apply=1.
REQ-007 weight_init  input  N  signed Q-format weight loaded at reset.
REQ-008 m1, b1  input  N each  signed Q-format potentiation slope and intercept.
REQ-009 m2, b2  input  N each  signed Q-format depression slope and intercept.
REQ-010 w_min, w_max  input  N each  signed Q-format clamp bounds.
REQ-011 weight  output  N  current signed Q-format synaptic weight.
REQ-012 update_valid  output  1  one-cycle pulse when weight takes a new value.
REQ-013 busy  output  1  high while an update is in flight.
REQ-014 overrun  output  1  one-cycle pulse when a qualifying pairing is dropped.

Function
REQ-015 Age counters pre_age/post_age (Q bits, unsigned) SHALL change only on apply: cleared to 0 if the matching spike is present, otherwise incremented, saturating at 2^Q-1.
REQ-016 Flags pre_seen/post_seen SHALL set on the first matching spike after reset and stay set.
REQ-017 Potentiation SHALL qualify on apply when post_spike=1, pre_spike=0, pre_seen=1: dt = pre_age+1 (value before this apply), coefficients m1/b1.
REQ-018 Depression SHALL qualify on apply when pre_spike=1, post_spike=0, post_seen=1: dt = post_age+1, coefficients m2/b2.
REQ-019 pre_spike=1 and post_spike=1 on the same apply SHALL produce no update; both ages clear.
REQ-020 Pairing SHALL be only with the most recent partner spike; a qualifying event with dt > T_WIN SHALL produce no update.
REQ-021 FSM states: IDLE, MUL, ADD, WRITE; IDLE->MUL on a qualifying apply; MUL->ADD->WRITE->IDLE unconditionally.
REQ-022 MUL SHALL register the 2N-bit signed product m*dt (dt as integer, no shift).
REQ-023 ADD SHALL form weight + product + b at full width, then saturate to the signed N-bit range.
REQ-024 WRITE SHALL load the result into weight and assert update_valid for exactly that cycle; the apply at cycle k gives weight/update_valid at cycle k+3.
REQ-025 busy SHALL be 1 in MUL, ADD and WRITE, and 0 in IDLE.
REQ-026 A qualifying apply while busy=1 SHALL be dropped, pulse overrun next cycle, and still update ages/flags.
REQ-027 Coefficient inputs SHALL be sampled on the qualifying apply cycle; later changes SHALL not affect that update.

Reset
REQ-028 On rst_n=0 at a clk edge: weight=weight_init, ages=0, pre_seen=post_seen=0, FSM=IDLE, update_valid=busy=overrun=0.
REQ-029 Reset mid-update SHALL abort it with no update_valid pulse; weight SHALL read weight_init.

Configuration
REQ-030 With macro STDP_WEIGHT_CLAMP_EN defined, the WRITE result SHALL additionally be clamped to [w_min, w_max] after saturation; without it, w_min/w_max SHALL be ignored and only N-bit saturation applies.

Verification
REQ-031 weight_init=0x00010000, m1=0x00001000, b1=0; pre on apply0, post on apply3 -> dt=3, weight=0x00013000, update_valid 3 cycles after apply3.
REQ-032 weight_init=0x00010000, m2=0xFFFFF000, b2=0; post on apply0, pre on apply2 -> dt=2, weight=0x0000E000.
REQ-033 After pre_seen and post_seen are both set, pre and post together on one apply -> no update_valid, weight unchanged, both ages 0.
REQ-034 Setup of REQ-031 with w_max=0x00011000 -> weight=0x00011000 with STDP_WEIGHT_CLAMP_EN, 0x00013000 without.
REQ-035 pre on apply0, post on apply25 (T_WIN=20) -> no update; a qualifying apply on the cycle after a qualifying apply -> one update_valid, one overrun pulse.
REQ-036 rst_n=0 while FSM is in MUL -> next cycle weight=weight_init, busy=0, no update_valid.
